// File: rtl/dbus_sram_responder_pkg.sv
// Shared data-bus types (common) and the responder FSM state type (pipes).
// Type definitions only; no timing or flow-control behaviour lives here.
package common;
  typedef logic [7:0] strobe_t;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    strobe_t     strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;
endpackage

package pipes;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dbus_resp_state_t;

  localparam int unsigned DBUS_CNT_W = 4;
endpackage

// File: rtl/dbus_sram_responder_if.sv
// Data-bus bundle between the memory stage (master) and a responder (slave).
// Request is held by the master until data_ok; no other flow control.
interface dbus_sram_responder_if;
  import common::*;

  dbus_req_t  dreq;
  dbus_resp_t dresp;

  modport master (output dreq, input dresp);
  modport slave  (input dreq, output dresp);
endinterface

// File: rtl/dbus_sram_responder_sram.sv
// Purpose: DEPTH x 64-bit single-port storage with per-byte write enables.
// Latency: combinational read, write committed at the rising edge.
// Backpressure: none; contents are deliberately not touched by reset.
module sram_bytewe #(
  parameter int DEPTH = 512
) (
  input  logic                     clk,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [7:0]               we,
  input  logic [63:0]              wdata,
  output logic [63:0]              rdata
);
  logic [63:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (we[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
    end
  end

  assign rdata = mem[addr];
endmodule

// File: rtl/dbus_sram_responder.sv
// Purpose: data-bus responder backed by a byte-writable SRAM, one transaction at a time.
// Latency: addr_ok/data_ok together LATENCY cycles after acceptance, then one idle bubble.
// Backpressure: initiator holds valid until data_ok; dropping valid early flushes the request.
module dbus_sram_responder
  import common::*;
  import pipes::*;
#(
  parameter int DEPTH   = 512,
  parameter int LATENCY = 2
) (
  input logic                  clk,
  input logic                  reset,
  dbus_sram_responder_if.slave dbus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [DBUS_CNT_W-1:0] CNT_INIT = DBUS_CNT_W'(LATENCY - 1);

  dbus_resp_state_t      state;
  logic [DBUS_CNT_W-1:0] cnt;
  logic [AW-1:0]         idx_q;
  strobe_t               strb_q;
  logic [63:0]           wdata_q;
  dbus_resp_t            resp_q;

  logic [AW-1:0] idx;
  logic [7:0]    we;
  logic [63:0]   rdata;
  logic          unused_req;

  // Only the word index is decoded; size, byte offset and alias bits are ignored.
  assign unused_req = ^{dbus.dreq.size, dbus.dreq.addr[63:3+AW], dbus.dreq.addr[2:0]};

  // In IDLE the live address feeds the read so LATENCY=1 can respond right after acceptance.
  assign idx = (state == IDLE) ? dbus.dreq.addr[3 +: AW] : idx_q;
  // The write lands on the edge that ends RESP, and only if the initiator still holds valid.
  assign we  = (state == RESP && dbus.dreq.valid) ? strb_q : 8'h00;

  sram_bytewe #(
    .DEPTH (DEPTH)
  ) u_sram (
    .clk   (clk),
    .addr  (idx),
    .we    (we),
    .wdata (wdata_q),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      idx_q   <= '0;
      strb_q  <= '0;
      wdata_q <= '0;
      resp_q  <= '0;
    end else begin
      resp_q <= '0;
      unique case (state)
        IDLE: begin
          if (dbus.dreq.valid) begin
            idx_q   <= dbus.dreq.addr[3 +: AW];
            strb_q  <= dbus.dreq.strobe;
            wdata_q <= dbus.dreq.data;
            cnt     <= CNT_INIT;
            if (LATENCY == 1) begin
              state  <= RESP;
              resp_q <= '{addr_ok: 1'b1, data_ok: 1'b1, data: rdata};
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!dbus.dreq.valid) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - 1'b1;
            if (cnt == DBUS_CNT_W'(1)) begin
              state  <= RESP;
              resp_q <= '{addr_ok: 1'b1, data_ok: 1'b1, data: rdata};
            end
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign dbus.dresp = resp_q;
endmodule

// File: tb/tb_dbus_sram_responder.sv
// Bench for dbus_sram_responder at LATENCY 2, 1 and 15 (DEPTH 512) against a
// behavioural memory model plus a table of hand-derived vectors.
module tb_dbus_sram_responder;
  import common::*;

  typedef struct {
    logic [63:0] addr;
    logic [7:0]  strb;
    logic [63:0] wdat;
    bit          chk;
    logic [63:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  int   cyc_n = 0;
  int   ok_cyc = 0;

  dbus_req_t   req [3];
  dbus_resp_t  rsp [3];
  logic [63:0] mm  [3][512];
  bit          kn  [3][512];
  int          lat_of [3] = '{2, 1, 15};
  vec_t        tbl [9];

  always #5 clk = ~clk;

  dbus_sram_responder_if bus0 ();
  dbus_sram_responder_if bus1 ();
  dbus_sram_responder_if bus2 ();

  assign bus0.dreq = req[0];
  assign bus1.dreq = req[1];
  assign bus2.dreq = req[2];
  assign rsp[0] = bus0.dresp;
  assign rsp[1] = bus1.dresp;
  assign rsp[2] = bus2.dresp;

  dbus_sram_responder #(.DEPTH(512), .LATENCY(2))  u_l2  (.clk(clk), .reset(reset), .dbus(bus0));
  dbus_sram_responder #(.DEPTH(512), .LATENCY(1))  u_l1  (.clk(clk), .reset(reset), .dbus(bus1));
  dbus_sram_responder #(.DEPTH(512), .LATENCY(15)) u_l15 (.clk(clk), .reset(reset), .dbus(bus2));

  task automatic cyc();
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic logic [63:0] resp_word(input int s);
    return rsp[s].data | 64'(rsp[s].addr_ok) | 64'(rsp[s].data_ok);
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] o, input logic [63:0] d, input logic [7:0] st);
    logic [63:0] r;
    r = o;
    for (int i = 0; i < 8; i++) if (st[i]) r[i*8 +: 8] = d[i*8 +: 8];
    return r;
  endfunction

  // Present a request in the current cycle and wait for data_ok; optionally
  // scramble the request fields while valid stays high.
  task automatic txn(input int s, input logic [63:0] a, input logic [7:0] st, input logic [63:0] d,
                     input bit scr, output logic [63:0] got, output int lat);
    req[s].valid  = 1'b1;
    req[s].addr   = a;
    req[s].size   = msize_t'($urandom_range(0, 3));
    req[s].strobe = st;
    req[s].data   = d;
    got = '0;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      cyc();
      if (scr) begin
        req[s].addr   = {$urandom, $urandom};
        req[s].strobe = 8'($urandom);
        req[s].data   = {$urandom, $urandom};
      end
      if (rsp[s].data_ok) begin
        chk("addr_ok_with_data_ok", 64'(rsp[s].addr_ok), 64'd1);
        got    = rsp[s].data;
        lat    = i;
        ok_cyc = cyc_n;
        break;
      end
      chk("quiet_before_resp", rsp[s].data | 64'(rsp[s].addr_ok), 64'd0);
    end
  endtask

  // One complete transaction checked against the model; ends in the bubble cycle with valid still high.
  task automatic run(input int s, input logic [63:0] a, input logic [7:0] st, input logic [63:0] d,
                     input bit scr, output logic [63:0] got);
    int          ix;
    int          lat;
    logic [63:0] old;
    bit          k;
    ix  = int'((a >> 3) % 64'd512);
    old = mm[s][ix];
    k   = kn[s][ix];
    txn(s, a, st, d, scr, got, lat);
    chk($sformatf("latency_L%0d", lat_of[s]), 64'(lat), 64'(lat_of[s]));
    if (k) chk($sformatf("rdata_L%0d", lat_of[s]), got, old);
    if (st != 8'h00) begin
      mm[s][ix] = merge(old, d, st);
      if (st == 8'hFF) kn[s][ix] = 1'b1;
    end
    cyc();
    chk("bubble_idle", resp_word(s), 64'd0);
  endtask

  task automatic idle(input int s);
    req[s].valid = 1'b0;
    cyc();
  endtask

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: got no completion, expected finish before timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] got;
    logic [63:0] a;
    logic [7:0]  st;
    bit          seen;
    int          prev;
    int          n;

    tbl[0] = '{64'h80,   8'hFF, 64'h1122334455667788, 1'b0, 64'h0};
    tbl[1] = '{64'h80,   8'h00, 64'h0,                1'b1, 64'h1122334455667788};
    tbl[2] = '{64'h80,   8'h0F, 64'hAAAAAAAABBBBBBBB, 1'b1, 64'h1122334455667788};
    tbl[3] = '{64'h80,   8'h00, 64'h0,                1'b1, 64'h11223344BBBBBBBB};
    tbl[4] = '{64'h1000, 8'hFF, 64'h5A,               1'b0, 64'h0};
    tbl[5] = '{64'h0,    8'h00, 64'h0,                1'b1, 64'h5A};
    tbl[6] = '{64'h0,    8'h80, 64'h7700000000000000, 1'b1, 64'h5A};
    tbl[7] = '{64'h1006, 8'h00, 64'h0,                1'b1, 64'h770000000000005A};
    tbl[8] = '{64'h84,   8'h00, 64'h0,                1'b1, 64'h11223344BBBBBBBB};

    for (int s = 0; s < 3; s++) req[s] = '0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    for (int s = 0; s < 3; s++) chk($sformatf("reset_dresp_L%0d", lat_of[s]), resp_word(s), 64'd0);
    cyc();
    cyc();
    reset = 1'b1;

    // Table vectors, issued back to back on the LATENCY=2 instance.
    for (int i = 0; i < 9; i++) begin
      run(0, tbl[i].addr, tbl[i].strb, tbl[i].wdat, 1'b0, got);
      if (tbl[i].chk) chk($sformatf("vec%0d", i), got, tbl[i].exp);
    end
    idle(0);

    // Read flushed in WAIT.
    req[0] = '{valid: 1'b1, addr: 64'h80, size: MSIZE8, strobe: 8'h00, data: 64'h0};
    cyc();
    req[0].valid = 1'b0;
    seen = 1'b0;
    repeat (6) begin cyc(); if (rsp[0].data_ok) seen = 1'b1; end
    chk("flush_wait_no_data_ok", 64'(seen), 64'd0);
    run(0, 64'h80, 8'h00, 64'h0, 1'b0, got);
    chk("flush_wait_next_read", got, 64'h11223344BBBBBBBB);
    idle(0);

    // Write flushed in RESP.
    req[0] = '{valid: 1'b1, addr: 64'h80, size: MSIZE8, strobe: 8'hFF, data: 64'hDEADBEEF0BADF00D};
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin cyc(); seen = rsp[0].data_ok; end
    chk("flush_resp_reached", 64'(seen), 64'd1);
    req[0].valid = 1'b0;
    seen = 1'b0;
    repeat (6) begin cyc(); if (rsp[0].data_ok) seen = 1'b1; end
    chk("flush_resp_no_data_ok", 64'(seen), 64'd0);
    run(0, 64'h80, 8'h00, 64'h0, 1'b0, got);
    chk("flush_resp_mem_unchanged", got, 64'h11223344BBBBBBBB);
    idle(0);

    // Reset while a full write waits.
    req[0] = '{valid: 1'b1, addr: 64'h80, size: MSIZE8, strobe: 8'hFF, data: 64'hFFFFFFFFFFFFFFFF};
    cyc();
    reset = 1'b0;
    #1;
    chk("reset_in_wait_dresp", resp_word(0), 64'd0);
    req[0].valid = 1'b0;
    cyc();
    reset = 1'b1;
    run(0, 64'h80, 8'h00, 64'h0, 1'b0, got);
    chk("reset_wait_mem_kept", got, 64'h11223344BBBBBBBB);

    // Reset asserted between edges while a write is in RESP.
    req[0] = '{valid: 1'b1, addr: 64'h80, size: MSIZE8, strobe: 8'hFF, data: 64'h0123456789ABCDEF};
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin cyc(); seen = rsp[0].data_ok; end
    chk("reset_resp_reached", 64'(seen), 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("async_reset_in_resp", resp_word(0), 64'd0);
    req[0].valid = 1'b0;
    cyc();
    reset = 1'b1;
    run(0, 64'h80, 8'h00, 64'h0, 1'b0, got);
    chk("reset_resp_no_write", got, 64'h11223344BBBBBBBB);
    idle(0);

    // Back-to-back reads with valid held, LATENCY=1 and LATENCY=15.
    for (int s = 1; s < 3; s++) begin
      for (int i = 0; i < 4; i++) run(s, 64'(i * 8), 8'hFF, 64'hC0DE000000000000 + 64'(i), 1'b0, got);
      prev = 0;
      for (int i = 0; i < 4; i++) begin
        run(s, 64'(i * 8), 8'h00, 64'h0, 1'b0, got);
        chk($sformatf("b2b_data_L%0d", lat_of[s]), got, 64'hC0DE000000000000 + 64'(i));
        if (i > 0) chk($sformatf("b2b_interval_L%0d", lat_of[s]), 64'(ok_cyc - prev), 64'(lat_of[s] + 1));
        prev = ok_cyc;
      end
      idle(s);
    end

    // Random traffic with aliasing addresses and in-flight request scrambling.
    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < 8; i++) run(s, 64'(i * 8), 8'hFF, {$urandom, $urandom}, 1'b1, got);
      n = (s == 2) ? 20 : 50;
      for (int k = 0; k < n; k++) begin
        a = {$urandom, $urandom};
        a[11:3] = 9'($urandom_range(0, 7));
        case ($urandom_range(0, 2))
          0:       st = 8'h00;
          1:       st = 8'hFF;
          default: st = 8'($urandom);
        endcase
        run(s, a, st, {$urandom, $urandom}, 1'b1, got);
      end
      idle(s);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dbus_sram_responder.md
DBUS_SRAM_RESPONDER -- requirements
Module: dbus_sram_responder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 512, meaning the number of 64-bit words of storage (power of two, ≥2).
REQ-002 The block SHALL have parameter LATENCY, default 2, meaning cycles from request acceptance to data_ok (1..15).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, reset that is asynchronous and active-low.
REQ-005 The block SHALL have port dreq, input, dbus_req_t, the data-bus request from the memory stage (valid, addr, size, strobe, data).
REQ-006 The block SHALL have port dresp, output, dbus_resp_t, the data-bus response (addr_ok, data_ok, data).

Function
REQ-007 The block SHALL be the responder end of the data bus driven by the memory stage: one outstanding transaction, no pipelining.
REQ-008 The block SHALL implement FSM states IDLE, WAIT, RESP.
REQ-009 In IDLE, dreq.valid=1 at a rising edge SHALL latch addr, strobe and data, load counter with LATENCY-1, and go to RESP if LATENCY=1, else WAIT.
REQ-010 In WAIT, the counter SHALL decrement each cycle; at counter=1 the next state SHALL be RESP.
REQ-011 In RESP, dresp.addr_ok and dresp.data_ok SHALL both be 1 for exactly one cycle; next state IDLE.
REQ-012 Word index SHALL be addr[3 +: log2(DEPTH)]; higher address bits ignored (aliasing); addr[2:0] ignored, byte lanes selected by strobe only.
REQ-013 Read: strobe=0 → dresp.data in RESP = full 64-bit word at index, unaligned extraction left to the initiator.
REQ-014 Write: strobe≠0 → byte lane i written with data[8i+7:8i] iff strobe[i]=1, committed at the edge ending RESP; dresp.data in RESP = old word contents.
REQ-015 dresp.data SHALL be 0 in every non-RESP cycle; addr_ok and data_ok SHALL be 0 outside RESP.
REQ-016 If dreq.valid drops while in WAIT or RESP (flush), the block SHALL return to IDLE next edge, commit no write, and not assert data_ok afterwards.
REQ-017 The latched request SHALL be used; dreq changes with valid held high SHALL NOT alter the transaction in flight.
REQ-018 A request present in the cycle after RESP SHALL be accepted in IDLE, giving one idle bubble between transactions; throughput = 1 per LATENCY+1 cycles.
REQ-019 dreq.size SHALL be ignored; strobe is authoritative.

Reset
REQ-020 reset=0 SHALL asynchronously force state IDLE, counter 0, latched request 0, and all dresp fields 0.
REQ-021 Reset mid-transaction SHALL abort it with no write; storage contents SHALL NOT be cleared by reset.
REQ-022 After reset release, the first rising edge with dreq.valid=1 SHALL be accepted.

Structure
REQ-023 dbus_req_t, dbus_resp_t, strobe_t and msize_t SHALL remain in package common; the FSM state enum SHALL be added to package pipes as dbus_resp_state_t.
REQ-024 Storage SHALL be a sub-module sram_bytewe (DEPTH×64, 8 byte-enables, 1 read/write port, asynchronous read), with FSM and counter in the top module.

Verification
REQ-025 Reset, LATENCY=2: write addr 0x80, strobe 0xFF, data 0x1122334455667788 → data_ok high exactly 2 cycles after acceptance; read of 0x80 returns 0x1122334455667788.
REQ-026 Partial write 0x80, strobe 0x0F, data 0xAAAAAAAA_BBBBBBBB over the prior word → readback 0x11223344BBBBBBBB.
REQ-027 Aliasing, DEPTH=512: write 0x1000 data 0x5A → read of 0x0 returns 0x5A.
REQ-028 Flush: read issued, valid dropped in WAIT; also write issued, valid dropped in RESP → no data_ok after the drop, memory unchanged, next request accepted.
REQ-029 Reset asserted in WAIT during write strobe 0xFF → dresp zero immediately (asynchronously); prior contents still readable.
REQ-030 Back-to-back: 4 reads with valid held continuously, LATENCY=1 → data_ok every 2nd cycle; LATENCY=15 → data_ok 15 cycles after each acceptance.
